// File: rtl/omem_pkg.sv
// ============================================================================
//  Module      : omem_pkg
//  Description : Shared defaults, FSM state and FIFO entry type for the
//                output-memory drain sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package omem_pkg;

  localparam int NBANK_DEF = 75;
  localparam int AW_DEF    = 7;
  localparam int DW_DEF    = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } omem_state_e;

  typedef struct packed {
    logic              last;
    logic [DW_DEF-1:0] data;
  } omem_entry_t;

endpackage

`default_nettype wire

// File: rtl/omem_drain_fifo.sv
// ============================================================================
//  Module      : omem_drain_fifo
//  Description : Two-entry synchronous FIFO with occupancy output; push and
//                pop may occur in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module omem_drain_fifo #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot this cycle.
  assign w_do_pop  = pop && (r_count != 2'd0);
  assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/omem_drain.sv
// ============================================================================
//  Module      : omem_drain
//  Description : Walks all output-memory banks once per start and streams the
//                read data on a valid/ready port with a last marker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module omem_drain
  import omem_pkg::*;
#(
  parameter int NBANK = NBANK_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_bank,
  input  logic [DW-1:0] mem_out,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam logic [AW-1:0] C_LAST_BANK = AW'(NBANK - 1);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  omem_state_e   r_state;
  logic [AW-1:0] r_ptr;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          r_done;

  logic [1:0]    w_count;
  logic          w_empty;
  logic          w_pop;
  logic          w_issue;
  entry_t        w_push_entry;
  entry_t        w_head;

  assign w_pop = out_valid && out_ready;

  // Issue only if the slot is guaranteed free when the read data lands.
  assign w_issue = (r_state == S_RUN) &&
                   (({1'b0, w_count} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop}));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_ptr == C_LAST_BANK);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (r_ptr == C_LAST_BANK) begin
              r_state <= S_FLUSH;
            end else begin
              r_ptr <= r_ptr + AW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (w_pop && out_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_push_entry.last = r_inflight_last;
  assign w_push_entry.data = mem_out;

  omem_drain_fifo #(
    .W ($bits(entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (r_inflight),
    .din     (w_push_entry),
    .pop     (w_pop),
    .dout    (w_head),
    .count   (w_count),
    .empty   (w_empty)
  );

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign mem_rd    = w_issue;
  assign mem_bank  = r_ptr;
  assign out_valid = !w_empty;
  assign out_data  = w_head.data;
  assign out_last  = w_head.last && !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_omem_drain.sv
// ============================================================================
//  Module      : tb_omem_drain
//  Description : Scoreboard bench for omem_drain (75-bank build plus a
//                single-bank build).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_omem_drain;

  localparam int NBANK = 75;
  localparam int AW    = 7;
  localparam int DW    = 9;
  localparam logic [DW-1:0] C_M1 = 9'h1A5;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, mem_rd, out_valid, out_last;
  logic [AW-1:0] mem_bank;
  logic [DW-1:0] mem_out = '0;
  logic [DW-1:0] out_data;

  logic          start1 = 1'b0;
  logic          ready1 = 1'b1;
  logic          busy1, done1, mem_rd1, valid1, last1;
  logic [0:0]    bank1;
  logic [DW-1:0] mem_out1 = '0;
  logic [DW-1:0] data1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] exp_q[$];

  always #5 clock = ~clock;

  omem_drain #(.NBANK(NBANK), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_bank(mem_bank), .mem_out(mem_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  omem_drain #(.NBANK(1), .AW(1), .DW(DW)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
    .mem_rd(mem_rd1), .mem_bank(bank1), .mem_out(mem_out1), .out_data(data1),
    .out_valid(valid1), .out_ready(ready1), .out_last(last1)
  );

  // Memory models: one-cycle registered read.
  always @(posedge clock) begin
    if (mem_rd) mem_out <= DW'((int'(mem_bank) * 3) % 512);
    if (mem_rd1) mem_out1 <= (bank1 == 1'b0) ? C_M1 : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    for (int b = 0; b < NBANK; b++)
      exp_q.push_back({(b == NBANK - 1), DW'((b * 3) % 512)});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input bit with_sb);
    start = 1'b1;
    if (with_sb) push_frame();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500; i++) begin
      tick();
      if (done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no done pulse expected done within 500 cycles", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_mem_rd"},    mem_rd,    0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_mem_bank"},  mem_bank,  0);
    check({tag, "_out_data"},  out_data,  0);
  endtask

  // Monitor: scoreboard pops, handshake hold, done timing, FIFO safety.
  logic        prev_stall     = 1'b0;
  logic        prev_last_xfer = 1'b0;
  logic [DW:0] prev_head      = '0;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      check("done_timing", done, prev_last_xfer);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_head", {out_last, out_data}, prev_head);
      end
      if (dut.r_inflight && dut.w_count == 2'd2 && !(out_valid && out_ready))
        check("fifo_overflow", 1, 0);
      if (mem_rd) check("bank_bound", (mem_bank <= AW'(NBANK - 1)), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got %0h expected no beat", {out_last, out_data});
        end else begin
          check("sb_word", {out_last, out_data}, exp_q.pop_front());
        end
      end
      prev_stall     = out_valid && !out_ready;
      prev_head      = {out_last, out_data};
      prev_last_xfer = out_valid && out_ready && out_last;
    end
  end

  initial begin
    int first_n;
    int last_n;
    int rd;
    bit seen;

    // Reset state
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Full frame, consumer always ready: latency and frame length
    out_ready = 1'b1;
    pulse_start(1'b1);
    first_n = -1;
    last_n  = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clock);
      if (out_valid && first_n < 0) first_n = n;
      if (out_valid && out_ready && out_last) begin
        last_n = n;
        break;
      end
    end
    check("first_valid_latency", first_n - 1, 2);
    check("last_beat_cycle", last_n, 77);
    wait_done("frame1_done");
    check("busy_low_at_done", busy, 0);
    tick();
    tick();

    // Backpressure: consumer stalls for 10 cycles after first valid
    out_ready = 1'b0;
    pulse_start(1'b1);
    rd   = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_rd) rd++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_first_valid", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_rd) rd++;
    end
    check("stall_reads", rd, 2);
    check("stall_data", out_data, 0);
    check("stall_valid", out_valid, 1);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_done("stall_done");
    tick();

    // Random consumer readiness
    pulse_start(1'b1);
    for (int i = 0; i < 2000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (!busy) break;
    end
    check("random_drained", exp_q.size(), 0);
    out_ready = 1'b0;

    // Consumer readiness toggling every cycle
    pulse_start(1'b1);
    for (int i = 0; i < 2000; i++) begin
      out_ready = ~out_ready;
      tick();
      if (!busy) break;
    end
    check("toggle_drained", exp_q.size(), 0);
    out_ready = 1'b1;
    tick();

    // Start while busy is ignored; start in the done cycle is accepted
    pulse_start(1'b1);
    repeat (4) tick();
    pulse_start(1'b0);
    repeat (34) tick();
    pulse_start(1'b0);
    wait_done("ignore_done");
    pulse_start(1'b1);
    check("restart_busy", busy, 1);
    wait_done("back2back_done");
    repeat (3) tick();
    check("idle_after_b2b_valid", out_valid, 0);
    check("idle_after_b2b_busy", busy, 0);
    check("b2b_drained", exp_q.size(), 0);

    // Asynchronous reset mid-drain
    pulse_start(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut.r_ptr == AW'(30)) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("reach_ptr30", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_reset_busy", busy, 0);
    pulse_start(1'b1);
    wait_done("post_reset_done");
    check("post_reset_drained", exp_q.size(), 0);

    // Single-bank build
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    first_n = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (valid1) begin
        first_n = n;
        break;
      end
    end
    check("nb1_latency", first_n - 1, 2);
    check("nb1_data", data1, C_M1);
    check("nb1_last", last1, 1);
    tick();
    check("nb1_done", done1, 1);
    check("nb1_busy", busy1, 0);
    tick();
    check("nb1_done_pulse", done1, 0);
    check("nb1_valid_after", valid1, 0);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
